// File: rtl/paddle_rc_decoder.sv
// ---------------------------------------------------------------------------
// paddle_rc_decoder
//
// Reader side of an AY-3-8500 style RC paddle. The external capacitor is
// discharged at frame start for a few scanlines. Charging then starts, and the
// block counts rising hs edges until the external comparator trips. The line
// count, minus a dead-zone offset and saturated to 8 bits, becomes the paddle
// position.
//
// Optional feature, selected by the macro PADDLE_AVG_EN:
//   defined   : the position is a 4-tap moving average of recent captures.
//               Timeout captures still strobe pos_valid but leave the position
//               and the history unchanged. The strobe comes one clock later.
//   undefined : the position is the current capture only. A timeout captures
//               raw = MAX_LINES, which saturates to 255.
// ---------------------------------------------------------------------------
module paddle_rc_decoder #(
    parameter int DISCHARGE_LINES = 4,
    parameter int OFFSET_LINES    = 16,
    parameter int MAX_LINES       = 300,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hs,
    input  logic       vs,
    input  logic       cmp_in,
    input  logic       invert,
    output logic       discharge,
    output logic [7:0] position,
    output logic       pos_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        MEASURE   = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    localparam logic [8:0] DIS_LAST  = 9'(DISCHARGE_LINES - 1);
    localparam logic [8:0] MEAS_LAST = 9'(MAX_LINES - 1);
    localparam logic [8:0] RAW_MAX   = 9'(MAX_LINES);
    localparam logic [8:0] OFFSET_9  = 9'(OFFSET_LINES);

    // Edge detection and comparator synchroniser.
    logic                   hs_r, hs_p, vs_r, vs_p;
    logic [SYNC_STAGES-1:0] cmp_sync;
    logic                   hs_rise, vs_rise, cmp_s;

    // Measurement state.
    state_t     state;
    logic [8:0] line_cnt;
    logic [8:0] raw_q;
    logic       cap_to;     // capture in progress is a timeout
    logic       cap_vs;     // capture was forced by vs, so restart discharge

    // Offset removal and saturation of the captured line count.
    logic [8:0] val;
    logic [7:0] sat;

`ifdef PADDLE_AVG_EN
    logic [7:0] hist [4];
    logic       avg_pend;
    logic       avg_to;
    logic       inv_q;
    logic [9:0] avg_sum;
`endif

    // Register hs/vs once for edge detection, and pass cmp_in through the sync chain.
    // NOTE: every sequential assignment uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_r     <= 1'b0;
            hs_p     <= 1'b0;
            vs_r     <= 1'b0;
            vs_p     <= 1'b0;
            cmp_sync <= '0;
        end else begin
            hs_r     <= hs;
            hs_p     <= hs_r;
            vs_r     <= vs;
            vs_p     <= vs_r;
            cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], cmp_in};
        end
    end

    assign hs_rise = hs_r & ~hs_p;
    assign vs_rise = vs_r & ~vs_p;
    assign cmp_s   = cmp_sync[SYNC_STAGES-1];

    // Remove the dead zone from the raw count and clamp the result to 8 bits.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        val = (raw_q < OFFSET_9) ? 9'd0 : raw_q - OFFSET_9;
        sat = (val > 9'd255) ? 8'hFF : val[7:0];
    end

`ifdef PADDLE_AVG_EN
    // Sum of the four history taps, read one cycle after they were updated.
    always_comb begin
        avg_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
    end
`endif

    // Measurement FSM with registered discharge, position, strobe and timeout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            discharge <= 1'b1;
            line_cnt  <= 9'd0;
            raw_q     <= 9'd0;
            cap_to    <= 1'b0;
            cap_vs    <= 1'b0;
            position  <= 8'h80;
            pos_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef PADDLE_AVG_EN
            // NOTE: the history is state that the output depends on, so it is
            // preset on reset rather than left undefined like a plain memory.
            for (int i = 0; i < 4; i++) hist[i] <= 8'h80;
            avg_pend  <= 1'b0;
            avg_to    <= 1'b0;
            inv_q     <= 1'b0;
`endif
        end else begin
            pos_valid <= 1'b0;

            case (state)
                IDLE: begin
                    discharge <= 1'b1;
                    if (vs_rise) begin
                        state    <= DISCHARGE;
                        line_cnt <= 9'd0;
                    end
                end

                DISCHARGE: begin
                    discharge <= 1'b1;
                    if (vs_rise) begin
                        line_cnt <= 9'd0;
                    end else if (hs_rise) begin
                        if (line_cnt == DIS_LAST) begin
                            state     <= MEASURE;
                            line_cnt  <= 9'd0;
                            discharge <= 1'b0;
                        end else begin
                            line_cnt <= line_cnt + 9'd1;
                        end
                    end
                end

                MEASURE: begin
                    discharge <= 1'b0;
                    if (vs_rise) begin
                        state     <= CAPTURE;
                        raw_q     <= RAW_MAX;
                        cap_to    <= 1'b1;
                        cap_vs    <= 1'b1;
                        discharge <= 1'b1;
                    end else if (hs_rise) begin
                        if (cmp_s) begin
                            state     <= CAPTURE;
                            raw_q     <= line_cnt;
                            cap_to    <= 1'b0;
                            cap_vs    <= 1'b0;
                            discharge <= 1'b1;
                        end else if (line_cnt == MEAS_LAST) begin
                            state     <= CAPTURE;
                            raw_q     <= RAW_MAX;
                            cap_to    <= 1'b1;
                            cap_vs    <= 1'b0;
                            discharge <= 1'b1;
                        end else begin
                            line_cnt <= line_cnt + 9'd1;
                        end
                    end
                end

                CAPTURE: begin
                    discharge <= 1'b1;
                    line_cnt  <= 9'd0;
                    state     <= (cap_vs || vs_rise) ? DISCHARGE : IDLE;
`ifdef PADDLE_AVG_EN
                    if (!cap_to) begin
                        hist[0] <= sat;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
                    end
                    avg_pend <= 1'b1;
                    avg_to   <= cap_to;
                    inv_q    <= invert;
`else
                    position  <= sat ^ {8{invert}};
                    pos_valid <= 1'b1;
                    timeout   <= cap_to;
`endif
                end

                default: begin
                    state     <= IDLE;
                    discharge <= 1'b1;
                end
            endcase

`ifdef PADDLE_AVG_EN
            // Publish the averaged position one cycle after the history update.
            if (avg_pend) begin
                avg_pend  <= 1'b0;
                pos_valid <= 1'b1;
                timeout   <= avg_to;
                if (!avg_to) begin
                    position <= avg_sum[9:2] ^ {8{inv_q}};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_paddle_rc_decoder.sv
// ---------------------------------------------------------------------------
// tb_paddle_rc_decoder
//
// Directed testbench for paddle_rc_decoder. A small reference model computes
// the expected position from the raw line count. The model follows
// PADDLE_AVG_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_paddle_rc_decoder;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       hs, vs, cmp_in, invert;
    logic       discharge;
    logic [7:0] position;
    logic       pos_valid;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // Strobe monitor state.
    int         pv_count  = 0;
    int         width_err = 0;
    logic       pv_prev   = 1'b0;
    logic [7:0] last_pos  = 8'h00;
    logic       last_to   = 1'b0;

    // Reference model state.
    logic [7:0] m_pos;
`ifdef PADDLE_AVG_EN
    logic [7:0] m_hist [4];
`endif

    paddle_rc_decoder dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .hs        (hs),
        .vs        (vs),
        .cmp_in    (cmp_in),
        .invert    (invert),
        .discharge (discharge),
        .position  (position),
        .pos_valid (pos_valid),
        .timeout   (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    // Sample the strobe on the falling edge: count it, record its data, and flag multi-cycle pulses.
    always @(negedge clk_sys) begin
        if (pos_valid) begin
            pv_count = pv_count + 1;
            last_pos = position;
            last_to  = timeout;
            if (pv_prev) width_err = width_err + 1;
        end
        pv_prev = pos_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 8'h80;
`ifdef PADDLE_AVG_EN
        for (int i = 0; i < 4; i++) m_hist[i] = 8'h80;
`endif
    endtask

    // Expected position after a capture of the given raw count.
    task automatic model_capture(input int raw, input bit to, input bit inv);
        int v;
        int s;
        v = (raw < 16) ? 0 : raw - 16;
        s = (v > 255) ? 255 : v;
`ifdef PADDLE_AVG_EN
        if (!to) begin
            int sum;
            m_hist[3] = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = 8'(s);
            sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
            m_pos = 8'(sum / 4) ^ {8{inv}};
        end
`else
        m_pos = 8'(s) ^ {8{inv}};
`endif
    endtask

    // Pulse hs and/or vs for one clock, then hold them low for three clocks.
    task automatic pulse(input bit do_hs, input bit do_vs);
        @(negedge clk_sys);
        hs = do_hs;
        vs = do_vs;
        @(negedge clk_sys);
        hs = 1'b0;
        vs = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    // Discharge phase of four lines: discharge stays high through three lines and drops after the fourth.
    task automatic discharge_phase(input string tag);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check({tag, "_dis_hi"}, discharge, 1);
        pulse(1'b1, 1'b0);
        check({tag, "_dis_lo"}, discharge, 0);
    endtask

    // Wait, with a bound, for exactly one new strobe, then compare it with the model.
    task automatic expect_strobe(input string tag, input int pv_start, input bit to);
        int n = 0;
        while (pv_count == pv_start && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (4) @(negedge clk_sys);
        check({tag, "_strobes"}, pv_count - pv_start, 1);
        check({tag, "_pos"}, last_pos, m_pos);
        check({tag, "_timeout"}, last_to, to);
    endtask

    // Measure phase: cmp_in rises before line index lines_low, and total hs edges are sent.
    task automatic measure(input string tag, input int lines_low, input int total);
        int pv_start;
        bit to;
        pv_start = pv_count;
        for (int i = 0; i < total; i++) begin
            if (i == lines_low) cmp_in = 1'b1;
            repeat (3) @(negedge clk_sys);
            pulse(1'b1, 1'b0);
        end
        to = (lines_low >= total);
        model_capture(to ? 300 : lines_low, to, invert);
        expect_strobe(tag, pv_start, to);
        cmp_in = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic frame(input string tag, input int lines_low, input int total);
        pulse(1'b0, 1'b1);
        discharge_phase(tag);
        measure(tag, lines_low, total);
    endtask

    initial begin
        int pv_snap;

        hs = 1'b0; vs = 1'b0; cmp_in = 1'b0; invert = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        // Reset state, and no activity without vs.
        check("rst_discharge", discharge, 1);
        check("rst_position", position, 8'h80);
        check("rst_pos_valid", pos_valid, 0);
        check("rst_timeout", timeout, 0);
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
        check("idle_no_strobe", pv_count, 0);
        check("idle_discharge", discharge, 1);

        // Nominal capture: raw 99 gives position 83, or 0xAC when inverted.
        frame("raw99", 99, 100);
        invert = 1'b1;
        frame("raw99_inv", 99, 100);
        invert = 1'b0;

        // No comparator trip: timeout after 300 lines.
        frame("tmo300", 1000, 300);

        // Boundaries of the offset and the saturation.
        frame("raw0", 0, 1);
        frame("raw10", 10, 11);
        frame("raw17", 17, 18);
        frame("raw299", 299, 300);

        // vs during DISCHARGE restarts the line count, so four more lines are needed.
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        discharge_phase("vs_in_dis");
        measure("vs_in_dis", 40, 41);

        // hs and vs together in MEASURE: timeout capture, then discharge restarts.
        pulse(1'b0, 1'b1);
        discharge_phase("hsvs");
        pv_snap = pv_count;
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        model_capture(300, 1'b1, invert);
        expect_strobe("hsvs", pv_snap, 1'b1);
        check("hsvs_dis_restart", discharge, 1);
        discharge_phase("hsvs_re");
        measure("hsvs_re", 50, 51);

        // Reset asserted mid-measurement.
        pulse(1'b0, 1'b1);
        discharge_phase("midrst");
        for (int i = 0; i < 30; i++) pulse(1'b1, 1'b0);
        pv_snap = pv_count;
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("midrst_discharge", discharge, 1);
        check("midrst_position", position, 8'h80);
        check("midrst_pos_valid", pos_valid, 0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        check("midrst_no_strobe", pv_count - pv_snap, 0);
        check("midrst_idle_dis", discharge, 1);
        check("midrst_pos_hold", position, m_pos);

        check("strobe_width", width_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
